// File: rtl/mux_scan_ctrl.sv
// Column scan controller for a 64-lane 32:1 mux: steps sel through columns 0..31, holds each
// column for dwell+1 cycles and captures the mux output on the last cycle of every column.
module mux_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [63:0]        mux_out,
    output logic [4:0]         sel,
    output logic               busy,
    output logic               sample_valid,
    output logic [63:0]        sample_data,
    output logic [4:0]         sample_col,
    output logic               frame_done,
    output logic [31:0]        active_mask
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [4:0]         sel_q, sel_d;
    logic [4:0]         col_q, col_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [63:0]        data_q, data_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        sel_d   = sel_q;
        col_d   = col_q;
        busy_d  = busy_q;
        data_d  = data_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                sel_d  = 5'd0;
                cnt_d  = '0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    dwell_d = dwell;
                end
            end
            StRun: begin
                if (stop) begin
                    // Abort wins over a coincident capture; the finished mask is kept.
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    sel_d   = 5'd0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (cnt_q == dwell_q) begin
                    valid_d       = 1'b1;
                    data_d        = mux_out;
                    col_d         = sel_q;
                    cnt_d         = '0;
                    sel_d         = sel_q + 5'd1;
                    acc_d[sel_q]  = |mux_out;
                    if (sel_q == 5'd31) begin
                        done_d = 1'b1;
                        mask_d = acc_d;
                        acc_d  = '0;
                        if (!continuous) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dwell_q <= '0;
            sel_q   <= 5'd0;
            col_q   <= 5'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            sel_q   <= sel_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
        end
    end

    assign sel          = sel_q;
    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_col   = col_q;
    assign frame_done   = done_q;
    assign active_mask  = mask_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: the expected sample stream is derived arithmetically from the
// start edge (sample every dwell+1 cycles, column = sample index mod 32).
module tb_mux_scan_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset, start, stop, continuous;
    logic [DW-1:0] dwell;
    logic [63:0]   mux_out;
    logic [4:0]    sel;
    logic          busy, sample_valid, frame_done;
    logic [63:0]   sample_data;
    logic [4:0]    sample_col;
    logic [31:0]   active_mask;

    logic [63:0]   pat [32];
    logic [31:0]   cur_mask;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    // Behavioural column mux: each column presents a fixed pattern word.
    assign mux_out = pat[sel];

    mux_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .sel          (sel),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_col   (sample_col),
        .frame_done   (frame_done),
        .active_mask  (active_mask)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: only column 5 = 1; mode 1: even columns nonzero; mode 2: random sparse
    task automatic set_pattern(input int mode);
        for (int c = 0; c < 32; c++) begin
            case (mode)
                0:       pat[c] = (c == 5) ? 64'h1 : 64'h0;
                1:       pat[c] = (c % 2 == 0) ? ({$urandom, $urandom} | 64'h1) : 64'h0;
                default: pat[c] = ($urandom_range(0, 2) == 0) ? 64'h0 : {$urandom, $urandom};
            endcase
        end
    endtask

    task automatic run_scan(input int d, input bit cont, input int nframes,
                            input int abort_at, input bit abort_reset);
        int          per, total, k, col;
        bit          ev, ed;
        logic        exp_busy;
        logic [31:0] fm;
        per   = d + 1;
        total = 32 * per * nframes;
        fm    = '0;
        for (int c = 0; c < 32; c++) fm[c] = (pat[c] != 64'h0);

        continuous = cont;
        dwell      = d[DW-1:0];
        stop       = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || sel !== 5'd0 || sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_latch: busy=%0b sel=%0d valid=%0b, required 1 0 0",
                     busy, sel, sample_valid);
        end

        for (int n = 1; n <= total; n++) begin
            dwell = DW'($urandom);
            start = ($urandom_range(0, 3) == 0);
            if (n == abort_at) begin
                start = 1'b0;
                if (abort_reset) reset = 1'b1;
                else             stop  = 1'b1;
                step();
                reset = 1'b0;
                stop  = 1'b0;
                checks++;
                if (abort_reset) begin
                    cur_mask = '0;
                    if (busy !== 0 || sel !== 0 || sample_valid !== 0 || frame_done !== 0 ||
                        sample_data !== 0 || sample_col !== 0 || active_mask !== 0) begin
                        errors++;
                        $display("FAIL reset_mid: busy=%0b sel=%0d v=%0b fd=%0b data=%h col=%0d mask=%h, required all 0",
                                 busy, sel, sample_valid, frame_done, sample_data, sample_col,
                                 active_mask);
                    end
                end else begin
                    if (busy !== 0 || sel !== 0 || sample_valid !== 0 || frame_done !== 0 ||
                        active_mask !== cur_mask) begin
                        errors++;
                        $display("FAIL stop_abort: busy=%0b sel=%0d v=%0b fd=%0b mask=%h, required 0 0 0 0 %h",
                                 busy, sel, sample_valid, frame_done, active_mask, cur_mask);
                    end
                end
                dwell = d[DW-1:0];
                return;
            end
            step();
            ev       = (n % per) == 0;
            k        = n / per;
            col      = ev ? (k - 1) % 32 : -1;
            ed       = ev && (col == 31);
            exp_busy = cont ? 1'b1 : (n < total);

            checks++;
            if (sample_valid !== ev) begin
                errors++;
                $display("FAIL valid n=%0d d=%0d: got %0b, required %0b", n, d, sample_valid, ev);
            end
            if (ev) begin
                checks++;
                if (sample_col !== col[4:0] || sample_data !== pat[col]) begin
                    errors++;
                    $display("FAIL sample n=%0d: col=%0d data=%h, required col=%0d data=%h",
                             n, sample_col, sample_data, col, pat[col]);
                end
            end
            checks++;
            if (frame_done !== ed) begin
                errors++;
                $display("FAIL frame_done n=%0d: got %0b, required %0b", n, frame_done, ed);
            end
            checks++;
            if (busy !== exp_busy || sel !== 5'(k % 32)) begin
                errors++;
                $display("FAIL busy_sel n=%0d: busy=%0b sel=%0d, required busy=%0b sel=%0d",
                         n, busy, sel, exp_busy, k % 32);
            end
            if (ed) cur_mask = fm;
            checks++;
            if (active_mask !== cur_mask) begin
                errors++;
                $display("FAIL mask n=%0d: got %h, required %h", n, active_mask, cur_mask);
            end
        end
        start = 1'b0;
        dwell = d[DW-1:0];
        if (cont) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            checks++;
            if (busy !== 0 || sample_valid !== 0 || sel !== 0 || active_mask !== cur_mask) begin
                errors++;
                $display("FAIL cont_stop: busy=%0b v=%0b sel=%0d mask=%h, required 0 0 0 %h",
                         busy, sample_valid, sel, active_mask, cur_mask);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; continuous = 1'b0; dwell = '0;
        set_pattern(2);
        step();
        step();
        reset = 1'b0; start = 1'b0;
        cur_mask = '0;
        checks++;
        if (busy !== 0 || sel !== 0 || sample_valid !== 0 || frame_done !== 0 ||
            sample_data !== 0 || sample_col !== 0 || active_mask !== 0) begin
            errors++;
            $display("FAIL reset: busy=%0b sel=%0d v=%0b fd=%0b data=%h col=%0d mask=%h, required all 0",
                     busy, sel, sample_valid, frame_done, sample_data, sample_col, active_mask);
        end
    endtask

    task automatic test_single_frame();
        set_pattern(0);
        run_scan(3, 1'b0, 1, 0, 1'b0);
        checks++;
        if (active_mask !== 32'h0000_0020 || busy !== 1'b0) begin
            errors++;
            $display("FAIL col5_frame: mask=%h busy=%0b, required 00000020 0", active_mask, busy);
        end
        set_pattern(2);
        run_scan(7, 1'b0, 1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_pattern(2);
            run_scan($urandom_range(0, 15), 1'b0, 1, 0, 1'b0);
        end
    endtask

    task automatic test_continuous();
        set_pattern(1);
        run_scan(0, 1'b1, 3, 0, 1'b0);
        checks++;
        if (active_mask !== 32'h5555_5555) begin
            errors++;
            $display("FAIL even_mask: got %h, required 55555555", active_mask);
        end
    endtask

    task automatic test_stop();
        int d;
        d = $urandom_range(1, 5);
        set_pattern(2);
        run_scan(d, 1'b1, 2, 11 * (d + 1), 1'b0);
        run_scan(0, 1'b1, 1, 11, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_pattern(2);
        run_scan(2, 1'b0, 1, 21 * 3, 1'b1);
        set_pattern(2);
        run_scan(2, 1'b0, 1, 0, 1'b0);
    endtask

    task automatic test_idle_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 0 || sel !== 0 || sample_valid !== 0) begin
                errors++;
                $display("FAIL idle_start_stop: busy=%0b sel=%0d v=%0b, required 0 0 0",
                         busy, sel, sample_valid);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        step();
    endtask

    task automatic test_dwell_max();
        set_pattern(2);
        run_scan((1 << DW) - 1, 1'b0, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_continuous();
        test_stop();
        test_reset_mid();
        test_idle_start_stop();
        test_dwell_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell (cycles-per-column) setting.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a scan frame; honoured only in IDLE.
REQ-005 stop  input  1  abort the current scan; return to IDLE.
REQ-006 continuous  input  1  1 = restart at column 0 after column 31; 0 = single frame.
REQ-007 dwell  input  DWELL_W  column hold time minus one (each column lasts dwell+1 cycles).
REQ-008 mux_out  input  64  combinational output of the 64-lane 32:1 column mux driven by sel.
REQ-009 sel  output  5  column select driven to the column mux.
REQ-010 busy  output  1  high while in RUN.
REQ-011 sample_valid  output  1  one-cycle pulse; sample_data/sample_col valid.
REQ-012 sample_data  output  64  mux_out captured at the last cycle of a column.
REQ-013 sample_col  output  5  column index of sample_data.
REQ-014 frame_done  output  1  one-cycle pulse marking completion of column 31.
REQ-015 active_mask  output  32  bit c = 1 if column c produced nonzero mux_out in the last completed frame.

Function
REQ-016 Two states: IDLE, RUN; all outputs registered.
REQ-017 IDLE: sel=0, busy=0; start=1 and stop=0 at an edge -> RUN, sel=0, dwell counter=0, dwell latched internally.
REQ-018 Latched dwell used for the whole frame (and subsequent continuous frames until IDLE); dwell changes during RUN ignored.
REQ-019 RUN, each cycle: counter != latched dwell -> counter+1; counter == latched dwell -> capture cycle.
REQ-020 Capture cycle: sample_data<=mux_out, sample_col<=sel, sample_valid<=1, counter<=0, sel<=sel+1 mod 32, frame accumulator bit[sel] <= (mux_out != 0).
REQ-021 sample_valid and frame_done deasserted in every cycle not following a capture edge; no back-to-back pulses possible unless dwell=0.
REQ-022 Capture of column 31: frame_done<=1 in same cycle as its sample_valid; active_mask<=accumulator including column 31; accumulator cleared.
REQ-023 At column-31 capture: continuous=1 -> remain RUN, sel=0; continuous=0 -> IDLE, busy=0, sel=0.
REQ-024 Latency: start sampled at edge E0 -> busy high after E0; first sample_valid after edge E0+dwell+1; frame_done after edge E0+32*(dwell+1).
REQ-025 stop=1 in RUN -> next state IDLE, sel=0, counter=0, accumulator cleared, active_mask unchanged, no sample_valid/frame_done; stop has priority over a simultaneous capture.
REQ-026 start during RUN ignored; start and stop together in IDLE -> stay IDLE.
REQ-027 dwell=0: every RUN cycle is a capture; sample_valid held high continuously; 32-cycle frames.
REQ-028 dwell at max (2^DWELL_W-1): counter must not overflow; column lasts 2^DWELL_W cycles.

Reset
REQ-029 reset=1 at an edge: state IDLE; sel, busy, sample_valid, sample_data, sample_col, frame_done, active_mask, counter, accumulator all 0.
REQ-030 reset overrides start, stop and any in-progress capture in the same cycle; mid-frame reset discards the frame.

Verification
REQ-031 dwell=3, continuous=0, mux_out = (sel==5 ? 64'h1 : 0) modeled, start pulse -> 32 sample_valid pulses 4 cycles apart, sample_col 0..31, sample_data=1 only at col 5, frame_done with col 31, active_mask=32'h0000_0020, then busy=0.
REQ-032 dwell=0, continuous=1, mux_out nonzero for even sel -> sample_valid constant high, frame_done every 32 cycles, active_mask=32'h5555_5555 after first frame.
REQ-033 Continuous scan, stop asserted on capture cycle of col 10 -> no sample for col 10, IDLE next cycle, sel=0, active_mask retains previous frame value.
REQ-034 dwell changed 3->7 mid-frame -> column spacing stays 4 cycles until IDLE; next start uses 8.
REQ-035 reset pulsed at col 20 of a frame -> all outputs 0 next cycle; new start produces a full clean frame starting at col 0.
REQ-036 start+stop same cycle in IDLE, and start pulses during RUN -> no state change, sample sequence unaffected.
